// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED control.
// Optional macro FETCH_PERF_CNT_EN adds a 16-bit fetch_count output counting valid fetches.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hBF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] fetch_count,
`endif
  output logic        halted
);

  localparam int unsigned AW = 16;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [15:0]     ifid_instr_q, ifid_instr_d;
  logic [AW-1:0]   ifid_pc_q, ifid_pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            halted_q, halted_d;
  logic            fetch_fire;

  // Next-state and IF/ID load; priority is halt_req > branch_taken > stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;
    fetch_fire   = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d      = HALTED;
          halted_d     = 1'b1;
          ifid_instr_d = NOP_INSTR;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b0;
        end else if (branch_taken) begin
          pc_d         = branch_target;
          ifid_instr_d = NOP_INSTR;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d         = pc_q + AW'(1);
          ifid_instr_d = imem_instr;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          fetch_fire   = 1'b1;
        end
      end
      HALTED: begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        halted_d     = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= RESET_PC;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  // Counts edges that load a real instruction into IF/ID; held stalls do not count.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (fetch_fire) begin
      fetch_count_d = fetch_count_q + 16'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 16'h0000;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  logic unused_fire;
  assign unused_fire = fetch_fire;
`endif

  assign imem_addr  = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = halted_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, giving the word address loaded into PC on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 16'hBF00, giving the bubble instruction injected into IF/ID.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID (hazard from decode/execute).
REQ-006 SHALL have port branch_taken  input  1  redirect fetch to branch_target.
REQ-007 SHALL have port branch_target  input  16  absolute word address of the redirect.
REQ-008 SHALL have port halt_req  input  1  stop fetching until reset.
REQ-009 SHALL have port imem_addr  output  16  word address to instruction memory.
REQ-010 SHALL have port imem_instr  input  16  instruction returned combinationally for imem_addr in the same cycle.
REQ-011 SHALL have port ifid_instr  output  16  registered instruction to decode.
REQ-012 SHALL have port ifid_pc  output  16  registered address of ifid_instr.
REQ-013 SHALL have port ifid_valid  output  1  ifid_instr is a real fetched instruction, not a bubble.
REQ-014 SHALL have port halted  output  1  FSM is in HALTED.

Function
REQ-015 SHALL drive imem_addr combinationally from the PC register; the instruction is captured into IF/ID in the same cycle it is addressed (fetch latency 1 cycle, addressed to IF/ID).
REQ-016 SHALL implement FSM states RUN and HALTED; RUN->HALTED on halt_req; HALTED->RUN only via rst.
REQ-017 In RUN with no stall, branch_taken or halt_req: PC <= PC+1 modulo 2^16 (16'hFFFF wraps to 16'h0000); IF/ID <= {imem_instr, PC, valid=1}.
REQ-018 In RUN with stall=1 and branch_taken=0: PC and all IF/ID outputs SHALL hold their values.
REQ-019 In RUN with branch_taken=1: PC <= branch_target; IF/ID <= {NOP_INSTR, PC, valid=0}; branch_taken SHALL override stall.
REQ-020 After a redirect, the next unstalled cycle SHALL fetch from branch_target with valid=1 (exactly one bubble per redirect).
REQ-021 halt_req SHALL override branch_taken and stall: PC holds; IF/ID <= {NOP_INSTR, PC, valid=0}; next state HALTED.
REQ-022 In HALTED: PC holds; ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc holds; stall, branch_taken and halt_req SHALL be ignored; halted=1.
REQ-023 branch_target SHALL be used unchanged (no offset arithmetic in this block).

Reset
REQ-024 With rst=1 at a rising edge: PC <= RESET_PC, state <= RUN, ifid_instr <= NOP_INSTR, ifid_pc <= RESET_PC, ifid_valid <= 0, halted <= 0.
REQ-025 rst SHALL take priority over all other inputs, including in HALTED and in mid-stall.
REQ-026 The first cycle after rst deasserts SHALL fetch RESET_PC with valid=1 unless stalled or redirected.

Configuration
REQ-027 With macro FETCH_PERF_CNT_EN defined: output fetch_count, 16 bits, reset to 0, SHALL increment (wrapping) on every edge where ifid_valid is loaded as 1.
REQ-028 Without FETCH_PERF_CNT_EN: fetch_count port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset, then 4 free cycles with imem returning 16'h2000,16'h4603,16'h2101,16'h460B -> ifid_pc 0,1,2,3 with those instructions, valid=1.
REQ-030 PC=5, stall=1 for 3 cycles -> imem_addr stays 5; IF/ID is unchanged for those 3 cycles; the cycle after release captures address 5.
REQ-031 PC=10, branch_taken=1 with target 16'h0004 and stall=1 -> IF/ID={16'hBF00,10,0}; next cycle ifid_pc=4, valid=1.
REQ-032 PC=16'hFFFF free run -> ifid_pc=16'hFFFF, then imem_addr=16'h0000.
REQ-033 halt_req=1 with branch_taken=1 at PC=27 -> halted=1, imem_addr stays 27, bubbles thereafter; rst -> PC=RESET_PC, halted=0.
REQ-034 FETCH_PERF_CNT_EN build: 5 valid fetches, 1 redirect, 2 stall cycles -> fetch_count=5.
